// File: rtl/branch_predictor_rv32i.sv
// Direct-mapped BHT/BTB with 2-bit counters plus execute-stage branch resolution.
// Optional build macro BRANCH_STATS_EN adds branch and mispredict counters.
module branch_predictor_rv32i #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] PC_new,
  input  logic [XLEN-1:0] PC_branch,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            cu_branch,
  input  logic [2:0]      cu_branchtype,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] PC_in,
  output logic            br_taken,
  output logic            mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b010,
    BR_GE  = 3'b011,
    BR_LTU = 3'b100,
    BR_GEU = 3'b101
  } br_type_e;

  logic             valid_q  [BHT_DEPTH];
  logic [TAG_W-1:0] tag_q    [BHT_DEPTH];
  logic [XLEN-1:0]  target_q [BHT_DEPTH];
  logic [1:0]       ctr_q    [BHT_DEPTH];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             ex_hit, cond;
  logic [1:0]       ctr_d;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Lookup reads the arrays before the edge, so a same-index update is not forwarded.
  assign pred_taken  = valid_q[if_idx] & (tag_q[if_idx] == if_tag) & ctr_q[if_idx][1];
  assign pred_target = target_q[if_idx];
  assign ex_hit      = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);

  always_comb begin
    cond = 1'b0;
    case (br_type_e'(cu_branchtype))
      BR_EQ:   cond = (in1 == in2);
      BR_NE:   cond = (in1 != in2);
      BR_LT:   cond = ($signed(in1) <  $signed(in2));
      BR_GE:   cond = ($signed(in1) >= $signed(in2));
      BR_LTU:  cond = (in1 <  in2);
      BR_GEU:  cond = (in1 >= in2);
      default: cond = 1'b0;
    endcase
  end

  assign br_taken   = cu_branch & ex_valid & cond;
  assign PC_in      = br_taken ? PC_branch : PC_new;
  assign mispredict = ex_valid & ((br_taken != ex_pred_taken) |
                                  (br_taken & ex_pred_taken & (ex_pred_target != PC_branch)));

  always_comb begin
    ctr_d = ctr_q[ex_idx];
    if (!ex_hit)
      ctr_d = br_taken ? 2'b10 : 2'b01;
    else if (br_taken)
      ctr_d = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
    else
      ctr_d = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
  end

  // A predicted-taken non-branch means the entry is stale: drop it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '{default: 1'b0};
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      ctr_q    <= '{default: 2'b01};
    end else if (ex_valid && cu_branch) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= PC_branch;
      ctr_q[ex_idx]    <= ctr_d;
    end else if (ex_valid && ex_pred_taken) begin
      valid_q[ex_idx]  <= 1'b0;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (ex_valid && cu_branch) stat_br_q <= stat_br_q + 32'd1;
      if (mispredict)            stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor_rv32i.sv
// Directed bench for branch_predictor_rv32i: per-cycle comparison against a
// behavioural predictor model plus hand-computed literal expectations.
module tb_branch_predictor_rv32i;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, PC_new, PC_branch, in1, in2;
  logic            cu_branch;
  logic [2:0]      cu_branchtype;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic [XLEN-1:0] PC_in;
  logic            br_taken, mispredict;
`ifdef BRANCH_STATS_EN
  logic [31:0]     stat_branches, stat_mispredicts;
`endif

  branch_predictor_rv32i #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .PC_new(PC_new), .PC_branch(PC_branch),
    .in1(in1), .in2(in2), .cu_branch(cu_branch), .cu_branchtype(cu_branchtype),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .PC_in(PC_in), .br_taken(br_taken), .mispredict(mispredict)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: one record per table slot, tag kept as the PC above the index.
  bit          mv   [DEPTH];
  int unsigned mtag [DEPTH];
  logic [31:0] mtgt [DEPTH];
  int          mctr [DEPTH];
  int unsigned m_branches, m_mispredicts;
  bit          model_ok = 0;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic int unsigned tagof(input logic [31:0] pc);
    return pc / (4 * DEPTH);
  endfunction

  function automatic bit m_cond(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return $signed(a) < $signed(b);
      3'd3: return $signed(a) >= $signed(b);
      3'd4: return a < b;
      3'd5: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_taken();
    return ex_valid && cu_branch && m_cond(cu_branchtype, in1, in2);
  endfunction

  function automatic bit m_mispred();
    bit t;
    t = m_taken();
    if (!ex_valid) return 1'b0;
    if (t != ex_pred_taken) return 1'b1;
    return t && ex_pred_taken && (ex_pred_target != PC_branch);
  endfunction

  always @(posedge clk) begin
    int  s;
    bit  t;
    s = slot(ex_pc);
    t = m_taken();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mv[i] = 0; mtag[i] = 0; mtgt[i] = '0; mctr[i] = 1;
      end
      m_branches = 0; m_mispredicts = 0;
      model_ok = 1;
    end else if (ex_valid) begin
      if (m_mispred()) m_mispredicts++;
      if (cu_branch) begin
        m_branches++;
        if (mv[s] && mtag[s] == tagof(ex_pc))
          mctr[s] = t ? ((mctr[s] + 1 > 3) ? 3 : mctr[s] + 1) : ((mctr[s] - 1 < 0) ? 0 : mctr[s] - 1);
        else
          mctr[s] = t ? 2 : 1;
        mv[s] = 1; mtag[s] = tagof(ex_pc); mtgt[s] = PC_branch;
      end else if (ex_pred_taken) begin
        mv[s] = 0;
      end
    end
  end

  always @(negedge clk) begin
    int s;
    bit ep;
    if (model_ok) begin
      s  = slot(if_pc);
      ep = mv[s] && mtag[s] == tagof(if_pc) && mctr[s] >= 2;
      chk("m_pred_taken", {31'd0, pred_taken}, {31'd0, ep});
      if (ep) chk("m_pred_target", pred_target, mtgt[s]);
      chk("m_br_taken", {31'd0, br_taken}, {31'd0, m_taken()});
      chk("m_PC_in", PC_in, m_taken() ? PC_branch : PC_new);
      chk("m_mispredict", {31'd0, mispredict}, {31'd0, m_mispred()});
`ifdef BRANCH_STATS_EN
      chk("m_stat_branches", stat_branches, m_branches);
      chk("m_stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif
    end
  end

  task automatic set_ex(input bit v, input bit br, input logic [2:0] t, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pbr,
                        input bit ept, input logic [31:0] etgt);
    ex_valid = v; cu_branch = br; cu_branchtype = t; ex_pc = pc; PC_new = pc + 32'd4;
    in1 = a; in2 = b; PC_branch = pbr; ex_pred_taken = ept; ex_pred_target = etgt;
  endtask

  task automatic idle();
    set_ex(0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int          exp_ctr [5] = '{3, 3, 3, 2, 1};
  bit          tk      [5] = '{1, 1, 1, 0, 0};

  initial begin
    rst = 1; if_pc = 32'h100; idle();
    nxt(); nxt();
    mid(); chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    nxt(); rst = 0;

    // First taken BEQ at 0x100, predicted not-taken
    set_ex(1, 1, 3'd0, 32'h100, 32'd5, 32'd5, 32'h80, 0, 32'h0);
    mid();
    chk("beq_br_taken", {31'd0, br_taken}, 32'd1);
    chk("beq_PC_in", PC_in, 32'h80);
    chk("beq_mispredict", {31'd0, mispredict}, 32'd1);
    chk("beq_rbw_pred", {31'd0, pred_taken}, 32'd0);
    nxt(); idle();
    mid();
    chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("alloc_pred_target", pred_target, 32'h80);
    chk("alloc_ctr", mctr[0], 32'd2);
    nxt();

    for (int i = 0; i < 5; i++) begin
      set_ex(1, 1, 3'd0, 32'h100, 32'd5, tk[i] ? 32'd5 : 32'd6, 32'h80, 1, 32'h80);
      mid(); chk("train_mispredict", {31'd0, mispredict}, {31'd0, !tk[i]});
      nxt(); chk("train_ctr", mctr[0], exp_ctr[i]);
    end
    idle(); mid(); chk("train_pred_off", {31'd0, pred_taken}, 32'd0); nxt();

    // Signed vs unsigned compare; target mismatch counts as mispredict
    set_ex(1, 1, 3'd2, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h320, 1, 32'h111);
    mid(); chk("blt_br_taken", {31'd0, br_taken}, 32'd1);
    chk("blt_tgt_mispredict", {31'd0, mispredict}, 32'd1); nxt();
    set_ex(1, 1, 3'd4, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h320, 0, 32'h0);
    mid(); chk("bltu_br_taken", {31'd0, br_taken}, 32'd0);
    chk("bltu_PC_in", PC_in, 32'h304); nxt();
    set_ex(1, 1, 3'd6, 32'h308, 32'd7, 32'd7, 32'h400, 0, 32'h0);
    mid(); chk("type6_br_taken", {31'd0, br_taken}, 32'd0); nxt();
    set_ex(0, 1, 3'd0, 32'h308, 32'd7, 32'd7, 32'h400, 1, 32'h400);
    mid(); chk("novalid_mispredict", {31'd0, mispredict}, 32'd0); nxt();

    // Aliasing: 0x100 and 0x140 share slot 0
    set_ex(1, 1, 3'd1, 32'h100, 32'd1, 32'd2, 32'h80, 0, 32'h0); nxt();
    set_ex(1, 1, 3'd1, 32'h100, 32'd1, 32'd2, 32'h80, 1, 32'h80); nxt();
    idle(); if_pc = 32'h100; mid(); chk("alias_base_pred", {31'd0, pred_taken}, 32'd1); nxt();
    if_pc = 32'h140; mid(); chk("alias_miss_pred", {31'd0, pred_taken}, 32'd0); nxt();
    set_ex(1, 1, 3'd5, 32'h140, 32'd9, 32'd3, 32'h500, 0, 32'h0); nxt();
    idle(); mid();
    chk("alias_new_pred", {31'd0, pred_taken}, 32'd1);
    chk("alias_new_target", pred_target, 32'h500);
    chk("alias_new_ctr", mctr[0], 32'd2); nxt();
    if_pc = 32'h100; mid(); chk("alias_old_gone", {31'd0, pred_taken}, 32'd0); nxt();

    // Reset wins over a simultaneous taken update
    rst = 1; set_ex(1, 1, 3'd0, 32'h204, 32'd0, 32'd0, 32'h600, 0, 32'h0); nxt();
    rst = 0; idle(); if_pc = 32'h204; mid();
    chk("rst_upd_pred", {31'd0, pred_taken}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("rst_stat_br", stat_branches, 32'd0);
    chk("rst_stat_mp", stat_mispredicts, 32'd0);
`endif
    nxt();

    // Predicted-taken non-branch invalidates the entry
    set_ex(1, 1, 3'd0, 32'h200, 32'd3, 32'd3, 32'h240, 0, 32'h0); nxt();
    idle(); if_pc = 32'h200; mid(); chk("nb_setup_pred", {31'd0, pred_taken}, 32'd1); nxt();
    set_ex(1, 0, 3'd0, 32'h200, 32'd1, 32'd2, 32'h999, 1, 32'h240);
    mid();
    chk("nb_mispredict", {31'd0, mispredict}, 32'd1);
    chk("nb_PC_in", PC_in, 32'h204);
    chk("nb_br_taken", {31'd0, br_taken}, 32'd0);
    nxt(); idle(); mid(); chk("nb_invalidated", {31'd0, pred_taken}, 32'd0); nxt();

    repeat (2) nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor_rv32i.md
BRANCH_PREDICTOR_RV32I -- requirements
Module: branch_predictor_rv32i

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter BHT_DEPTH, default 16, predictor entry count, power of 2, min 2; IDX_W = log2(BHT_DEPTH), TAG_W = XLEN-2-IDX_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port if_pc  input  XLEN  fetch-stage PC for lookup.
REQ-006 SHALL have port pred_taken  output  1  fetch prediction: take branch.
REQ-007 SHALL have port pred_target  output  XLEN  predicted target, valid when pred_taken=1.
REQ-008 SHALL have port ex_valid  input  1  execute-stage instruction valid.
REQ-009 SHALL have port ex_pc  input  XLEN  PC of execute-stage instruction.
REQ-010 SHALL have port PC_new  input  XLEN  ex_pc + 4.
REQ-011 SHALL have port PC_branch  input  XLEN  ex_pc + imm from ALU.
REQ-012 SHALL have ports in1, in2  input  XLEN each  rs1, rs2 operands.
REQ-013 SHALL have port cu_branch  input  1  instruction is conditional branch.
REQ-014 SHALL have port cu_branchtype  input  3  000 BEQ, 001 BNE, 010 BLT, 011 BGE, 100 BLTU, 101 BGEU.
REQ-015 SHALL have ports ex_pred_taken  input  1, ex_pred_target  input  XLEN  prediction carried down the pipeline.
REQ-016 SHALL have port PC_in  output  XLEN  resolved correct next PC.
REQ-017 SHALL have ports br_taken  output  1, mispredict  output  1  resolution result and redirect request.

Function
REQ-018 SHALL hold per entry: valid bit, TAG_W tag, XLEN target, 2-bit saturating counter; index = pc[IDX_W+1:2], tag = pc[XLEN-1:IDX_W+2].
REQ-019 SHALL compute pred_taken = valid & tag match & counter[1], combinationally from if_pc; pred_target = entry target.
REQ-020 SHALL compute br_taken combinationally: cu_branch & ex_valid & condition; signed compare for BLT/BGE, unsigned for BLTU/BGEU; types 110/111 give br_taken=0.
REQ-021 SHALL drive PC_in = br_taken ? PC_branch : PC_new, combinationally (zero latency).
REQ-022 SHALL assert mispredict when ex_valid and (br_taken != ex_pred_taken, or br_taken & ex_pred_taken & ex_pred_target != PC_branch); ex_valid=0 forces mispredict=0.
REQ-023 SHALL, when ex_pred_taken=1 on a non-branch (cu_branch=0), assert mispredict, PC_in=PC_new, and clear that entry's valid bit at next edge.
REQ-024 SHALL update on edge when ex_valid & cu_branch: tag and target written, valid set; counter +1 if taken (saturate 11), -1 if not (saturate 00).
REQ-025 SHALL allocate a new/tag-mismatched entry with counter 10 if taken, 01 if not taken; not-taken miss SHALL still allocate.
REQ-026 SHALL give lookup read-before-write: if_pc index equal to update index in same cycle returns pre-update contents.
REQ-027 SHALL keep all entries unchanged when ex_valid=0 or rst=1.

Reset
REQ-028 SHALL on rst clear all valid bits, set all counters 01, zero tags/targets and statistics counters.
REQ-029 SHALL give rst priority over a simultaneous update; combinational outputs follow inputs during reset (pred_taken=0 after first reset edge).

Configuration
REQ-030 SHALL with macro BRANCH_STATS_EN defined add outputs stat_branches and stat_mispredicts (32 bits each), incremented on ex_valid&cu_branch and on mispredict respectively, wrapping modulo 2^32.
REQ-031 SHALL without BRANCH_STATS_EN omit both ports and counters; all other behaviour identical.

Verification
REQ-032 SHALL cover: reset, if_pc=0x100 -> pred_taken=0; BEQ at 0x100 in1=in2=5, ex_pred_taken=0, PC_branch=0x80 -> PC_in=0x80, mispredict=1; next cycle lookup 0x100 -> pred_taken=1, pred_target=0x80.
REQ-033 SHALL cover: same branch taken 3 more times then not-taken twice -> counter 11,11,11,10,01; pred_taken=0 after second not-taken.
REQ-034 SHALL cover: BLT in1=-1 in2=1 -> br_taken=1; BLTU same operands -> br_taken=0.
REQ-035 SHALL cover: aliasing 0x100 and 0x100+4*BHT_DEPTH -> second lookup pred_taken=0 (tag mismatch); update replaces entry.
REQ-036 SHALL cover: rst asserted same cycle as taken update -> entry stays invalid; with BRANCH_STATS_EN, stat counters read 0.
REQ-037 SHALL cover: ex_pred_taken=1, cu_branch=0, PC_new=0x204 -> mispredict=1, PC_in=0x204, entry invalidated next cycle.
